multicycle_control: RTL

- Multi-cycle sequencer for the 16-bit, 4-register datapath: a Moore FSM decodes IR[15:12] and issues per-state control strobes to the PC, IR, register file, ALU and a shared instruction/data memory port.
- Replaces the single-cycle MainControl/ALUControl pair. Memory accesses stall on a ready handshake.
- Also counts retired instructions.

---
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer for the 16-bit, 4-register multi-cycle
// datapath. It decodes IR[15:12], drives per-state strobes to the PC, IR,
// register file, ALU and the shared memory port, stalls memory accesses on
// mem_ready, and counts retired instructions.
// Optional build macro MC_HALT_EN: opcode 1111 enters a terminal HALT state
// (encoding 11) that retires the instruction on entry. Without it, 1111 traps.
module multicycle_control #(
    parameter int         CNT_W   = 16,
    parameter logic [2:0] ALU_ADD = 3'b010
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctl,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        R_WB     = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10,
        HALT     = 4'd11
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   retire;

    // The zero flag gates pc_write_cond inside the datapath; the sequencer
    // only exposes the port so both blocks share one connection list.
    logic   unused_zero;
    assign unused_zero = zero;

    function automatic logic [2:0] rtype_ctl(input logic [3:0] op);
        case (op)
            4'b0001: rtype_ctl = ALU_SUB;
            4'b0010: rtype_ctl = ALU_AND;
            4'b0011: rtype_ctl = ALU_OR;
            4'b0111: rtype_ctl = ALU_SLT;
            default: rtype_ctl = ALU_ADD;
        endcase
    endfunction

    // State register, forced to FETCH asynchronously by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cur_state <= FETCH;
        else          cur_state <= nxt_state;
    end

    // Next-state selection and the per-instruction retire pulse.
    always_comb begin
        nxt_state = cur_state;
        retire    = 1'b0;
        case (cur_state)
            FETCH:    if (mem_ready) nxt_state = DECODE;
            DECODE: begin
                case (opcode)
                    4'b0000, 4'b0001, 4'b0010,
                    4'b0011, 4'b0111:  nxt_state = EXEC_R;
                    4'b0100:           nxt_state = EXEC_I;
                    4'b0101, 4'b0110:  nxt_state = MEM_ADDR;
                    4'b1000:           nxt_state = BRANCH;
`ifdef MC_HALT_EN
                    4'b1111: begin
                        nxt_state = HALT;
                        retire    = 1'b1;
                    end
`endif
                    default:           nxt_state = TRAP;
                endcase
            end
            EXEC_R:   nxt_state = R_WB;
            EXEC_I:   nxt_state = R_WB;
            MEM_ADDR: nxt_state = (opcode == 4'b0110) ? MEM_WR : MEM_RD;
            MEM_RD:   if (mem_ready) nxt_state = MEM_WB;
            R_WB, MEM_WB, BRANCH: begin
                nxt_state = FETCH;
                retire    = 1'b1;
            end
            MEM_WR: begin
                if (mem_ready) begin
                    nxt_state = FETCH;
                    retire    = 1'b1;
                end
            end
            default:  nxt_state = cur_state;  // TRAP and HALT are terminal
        endcase
    end

    // Moore strobe decode; FETCH qualifies its PC/IR loads with mem_ready so
    // the PC advances exactly once per fetched instruction.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_ctl       = 3'b000;
        case (cur_state)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = 2'b01;
                alu_ctl   = ALU_ADD;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_ctl   = ALU_ADD;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctl   = rtype_ctl(opcode);
            end
            EXEC_I, MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = ALU_ADD;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = (opcode != 4'b0100);
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctl       = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            default: ;
        endcase
    end

    // Retired-instruction counter; wraps silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    retired <= '0;
        else if (retire) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Sticky illegal-opcode flag, raised on entry to TRAP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)               illegal <= 1'b0;
        else if (nxt_state == TRAP) illegal <= 1'b1;
    end

    assign state = cur_state;

endmodule
